// File: rtl/carryskip_pkg.sv
// Shared types and constants for the byte-serial add scheduler: FSM states,
// the shared adder's byte width and the signed-overflow helper.
package carryskip_pkg;

    localparam int BYTE_W = 8;
    // Byte index width covers NBYTES up to 4
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry into the MSB is recovered from the MSB sum bit and its operands
    function automatic logic ovf_bit(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic cout
    );
        return (a_msb ^ b_msb ^ sum_msb) ^ cout;
    endfunction

endpackage

// File: rtl/carryskip_rr_arb2.sv
// Two-way round-robin grant, purely combinational (0 cycles); grants only when
// i_en is high, the requester that was not served last wins a tie.
module carryskip_rr_arb2 (
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_gnt_id
);

    logic w_pick1;

    always_comb begin
        w_pick1  = (i_req0 && i_req1) ? ~i_last_grant : i_req1;
        o_gnt0   = i_en && i_req0 && !w_pick1;
        o_gnt1   = i_en && i_req1 && w_pick1;
        o_gnt_id = w_pick1;
    end

endmodule

// File: rtl/carryskip_add_sched.sv
// Serialises W-bit adds from two requesters through one external 8-bit adder, one byte per cycle; result valid NBYTES cycles after accept and held until rsp_ready.
// Optional signed-overflow output rsp_ovf is built when CARRYSKIP_ADD_SCHED_OVF_EN is defined.
module carryskip_add_sched
    import carryskip_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    output logic [BYTE_W-1:0] add_a,
    output logic [BYTE_W-1:0] add_b,
    output logic              add_cin,
    input  logic [BYTE_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_id,
    output logic              busy
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
    ,
    output logic              rsp_ovf
`endif
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_last_grant;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_id;
    logic               r_rsp_valid;
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
    logic               r_ovf;
`endif

    logic               w_arb_en;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_gnt_id;
    logic               w_accept;
    logic               w_run;
    logic               w_last_byte;
    logic [BYTE_W-1:0]  w_a_byte;
    logic [BYTE_W-1:0]  w_b_byte;

    // Readies must stay low while reset is held, even though the state reads IDLE
    assign w_arb_en = (r_state == IDLE) && !rst;

    carryskip_rr_arb2 u_arb (
        .i_en         (w_arb_en),
        .i_req0       (req0_valid),
        .i_req1       (req1_valid),
        .i_last_grant (r_last_grant),
        .o_gnt0       (w_gnt0),
        .o_gnt1       (w_gnt1),
        .o_gnt_id     (w_gnt_id)
    );

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign w_accept    = w_gnt0 || w_gnt1;
    assign w_run       = (r_state == RUN);
    assign w_last_byte = (r_idx == IDX_W'(NBYTES - 1));

    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_byte = r_a[i*BYTE_W +: BYTE_W];
                w_b_byte = r_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign add_a   = w_run ? w_a_byte : '0;
    assign add_b   = w_run ? w_b_byte : '0;
    assign add_cin = w_run && r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
            r_ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt0 ? req0_a : req1_a;
                        r_b     <= w_gnt0 ? req0_b : req1_b;
                        r_id    <= w_gnt_id;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*BYTE_W +: BYTE_W] <= add_sum;
                        end
                    end
                    r_carry <= add_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last_byte) begin
                        r_cout      <= add_cout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
                        r_ovf       <= ovf_bit(add_a[BYTE_W-1], add_b[BYTE_W-1],
                                               add_sum[BYTE_W-1], add_cout);
`endif
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_last_grant <= r_id;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
    assign rsp_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_carryskip_add_sched.sv
// Bench for carryskip_add_sched (NBYTES=2) with an 8-bit adder model, a
// whole-word arithmetic reference and a response scoreboard.
module tb_carryskip_add_sched;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [7:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout;
    logic          rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
    logic [W-1:0]  rsp_sum;
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
    logic          rsp_ovf;
`endif

    carryskip_add_sched #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    // External shared 8-bit adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    bit   m_idle     = 1'b1;
    bit   m_last     = 1'b1;
    int   m_acc_cyc  = 0;
    bit   acc0       = 1'b0;
    bit   acc1       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic id);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.id   = id;
        e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: checks handshake signals against the model, scores responses
    always @(negedge clk) begin
        int   win;
        exp_t e;
        if (rst) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            chk("rst_rsp_id", rsp_id, 0);
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
            chk("rst_rsp_ovf", rsp_ovf, 0);
`endif
            exp_q.delete();
            m_idle = 1'b1;
            m_last = 1'b1;
        end else begin
            win = -1;
            if (m_idle) begin
                if (req0_valid && req1_valid) win = m_last ? 0 : 1;
                else if (req0_valid)          win = 0;
                else if (req1_valid)          win = 1;
            end
            chk("req0_ready", req0_ready, win == 0);
            chk("req1_ready", req1_ready, win == 1);
            chk("busy", busy, !m_idle);
            chk("rsp_valid", rsp_valid, !m_idle && (cyc >= m_acc_cyc + 1 + NB));
            if (req0_valid && req0_ready) begin
                exp_q.push_back(model(req0_a, req0_b, 1'b0));
                grant_log.push_back(0);
                m_idle = 1'b0; m_acc_cyc = cyc; acc0 = 1'b1;
            end else if (req1_valid && req1_ready) begin
                exp_q.push_back(model(req1_a, req1_b, 1'b1));
                grant_log.push_back(1);
                m_idle = 1'b0; m_acc_cyc = cyc; acc1 = 1'b1;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid=1, expected no response", cyc);
                end else begin
                    e = exp_q[0];
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_cout", rsp_cout, e.cout);
                    chk("rsp_id", rsp_id, e.id);
`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
                    chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
                    if (rsp_ready) begin
                        m_last = e.id;
                        m_idle = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_acc(input int who);
        for (int n = 0; n <= 100; n++) begin
            @(posedge clk); #1;
            if (who == 0 && acc0) begin acc0 = 1'b0; return; end
            if (who == 1 && acc1) begin acc1 = 1'b0; return; end
        end
        vectors++; miscompares++;
        $display("FAIL accept_timeout: requester %0d not accepted, expected accept within 100 cycles", who);
    endtask

    task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else          begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        wait_acc(who);
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n <= 200; n++) begin
            @(posedge clk); #1;
            if (m_idle && exp_q.size() == 0) return;
        end
        vectors++; miscompares++;
        $display("FAIL idle_timeout: scoreboard holds %0d entries, expected 0", exp_q.size());
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Carry across the byte boundary, then full wraparound with carry out
        issue(0, 16'h00FF, 16'h0001); wait_idle();
        issue(1, 16'hFFFF, 16'h0001); wait_idle();

        // Both requesters continuously asking after reset: grants must alternate
        pulse_reset(2);
        grant_log.delete();
        acc0 = 1'b0; acc1 = 1'b0;
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 100 && n < 3; k++) begin
            @(posedge clk); #1;
            if (acc0) begin acc0 = 1'b0; n++; req0_a = W'($urandom); req0_b = W'($urandom); end
            if (acc1) begin acc1 = 1'b0; n++; req1_a = W'($urandom); req1_b = W'($urandom); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("grant_count", grant_log.size(), 3);
        if (grant_log.size() >= 3) begin
            chk("grant_order0", grant_log[0], 0);
            chk("grant_order1", grant_log[1], 1);
            chk("grant_order2", grant_log[2], 0);
        end

        // Response back-pressure while the other requester waits
        rsp_ready = 1'b0;
        issue(0, 16'h1234, 16'h4321);
        req1_a = 16'hBEEF; req1_b = 16'h0F0F; req1_valid = 1'b1;
        repeat (NB + 6) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_acc(1);
        req1_valid = 1'b0;
        wait_idle();

        // Reset one cycle into an operation aborts it without a response
        issue(0, 16'hAAAA, 16'h5555);
        @(posedge clk); #1;
        pulse_reset(1);
        repeat (4) @(posedge clk);
        #1 issue(1, 16'h1357, 16'h2468);
        wait_idle();

`ifdef CARRYSKIP_ADD_SCHED_OVF_EN
        issue(0, 16'h7FFF, 16'h0001); wait_idle();
        issue(1, 16'h8000, 16'h8000); wait_idle();
`endif

        // Random traffic with random back-pressure
        acc0 = 1'b0; acc1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (acc0) begin acc0 = 1'b0; req0_valid = 1'b0; end
            if (acc1) begin acc1 = 1'b0; req1_valid = 1'b0; end
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_a = rnd_op(); req0_b = rnd_op(); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_a = rnd_op(); req1_b = rnd_op(); req1_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
